alu_rs_sched: RTL and testbench

ALU_RS_SCHED -- requirements
Module: alu_rs_sched

---
 rtl/alu_rs_sched_pkg.sv | 30 +++
 rtl/alu_rs_select.sv | 47 ++++
 rtl/alu_rs_sched.sv | 170 +++++++++++++++++
 tb/tb_alu_rs_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_sched_pkg.sv
// Shared CPU definitions for the ALU reservation station: operand/tag types,
// the UNLOCKED tag value, the entry record and the CDB tag-match helper.
package alu_rs_sched_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regtag_t;
  typedef logic [4:0]  regaddr_t;
  typedef logic [5:0]  sinst_t;

  localparam regtag_t UNLOCKED = 5'd0;
  localparam word_t   ZERO     = 32'd0;

  typedef struct packed {
    sinst_t   op;
    addr_t    pc;
    regtag_t  tagx;
    regtag_t  tagy;
    word_t    datax;
    word_t    datay;
    regaddr_t target;
  } rs_entry_t;

  // Tag 0 means "value present", so a broadcast on tag 0 never wakes anything.
  function automatic logic tag_hit(input regtag_t tag, input logic cdb_en,
                                   input regtag_t cdb_tag);
    return cdb_en && (cdb_tag != UNLOCKED) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Age-matrix picker: tracks allocation order of reservation entries and grants
// the oldest requesting entry (one-hot).
module alu_rs_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             alloc_en,
  input  logic [DEPTH-1:0] alloc_sel,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else if (alloc_en) begin
        // New entry is younger than everything: clear its row, set its column.
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_sel[i]) older[i] <= '0;
          else              older[i] <= older[i] | alloc_sel;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && req[j] && older[j][i]) blocked = 1'b1;
      end
      grant[i] = req[i] && !blocked;
    end
  end

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station: holds dispatched ops, snoops the CDB, issues the
// oldest ready op to the ALU. Optional counters enabled by ALU_RS_PERF_EN.
module alu_rs_sched
  import alu_rs_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  sinst_t      disp_op,
  input  addr_t       disp_pc,
  input  regtag_t     disp_tagx,
  input  regtag_t     disp_tagy,
  input  word_t       disp_datax,
  input  word_t       disp_datay,
  input  regaddr_t    disp_target,
  input  logic        cdb_en,
  input  regtag_t     cdb_tag,
  input  word_t       cdb_data,
  input  logic        alu_ready,
  input  logic        flush,
  output logic        iss_valid,
  output sinst_t      iss_op,
  output addr_t       iss_pc,
  output word_t       iss_datax,
  output word_t       iss_datay,
  output regaddr_t    iss_target,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_full_cycles
);

  // Dispatch handshake: a transfer happens on an edge where disp_valid and
  // disp_ready are both high (and rdy high, flush low); disp_ready never
  // depends on disp_valid.

  rs_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] alloc_sel;
  logic [DEPTH-1:0] grant;
  logic             do_disp;
  logic             do_issue;
  rs_entry_t        new_ent;
  rs_entry_t        sel_ent;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid[i] && (ent[i].tagx == UNLOCKED) && (ent[i].tagy == UNLOCKED);
    end
  end

  // Only entries free before this edge count, so an issued slot is reused next edge at the earliest.
  assign free_vec   = ~valid;
  assign disp_ready = |free_vec;
  assign alloc_sel  = free_vec & (~free_vec + DEPTH'(1));
  assign do_disp    = rdy && !flush && disp_valid && disp_ready;
  assign do_issue   = rdy && !flush && alu_ready && (|ready_vec);

  always_comb begin
    new_ent.op     = disp_op;
    new_ent.pc     = disp_pc;
    new_ent.target = disp_target;
    new_ent.tagx   = disp_tagx;
    new_ent.datax  = disp_datax;
    new_ent.tagy   = disp_tagy;
    new_ent.datay  = disp_datay;
    // Catch a result broadcast in the same cycle the consumer is dispatched.
    if (tag_hit(disp_tagx, cdb_en, cdb_tag)) begin
      new_ent.tagx  = UNLOCKED;
      new_ent.datax = cdb_data;
    end
    if (tag_hit(disp_tagy, cdb_en, cdb_tag)) begin
      new_ent.tagy  = UNLOCKED;
      new_ent.datay = cdb_data;
    end
  end

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_ent = ent[i];
    end
  end

  alu_rs_select #(.DEPTH(DEPTH)) u_select (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (flush),
    .alloc_en  (do_disp),
    .alloc_sel (alloc_sel),
    .req       (ready_vec),
    .grant     (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (do_issue && grant[i]) begin
            valid[i] <= 1'b0;
          end else if (do_disp && alloc_sel[i]) begin
            valid[i] <= 1'b1;
            ent[i]   <= new_ent;
          end else if (valid[i]) begin
            if (tag_hit(ent[i].tagx, cdb_en, cdb_tag)) begin
              ent[i].tagx  <= UNLOCKED;
              ent[i].datax <= cdb_data;
            end
            if (tag_hit(ent[i].tagy, cdb_en, cdb_tag)) begin
              ent[i].tagy  <= UNLOCKED;
              ent[i].datay <= cdb_data;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid  <= 1'b0;
      iss_op     <= '0;
      iss_pc     <= ZERO;
      iss_datax  <= ZERO;
      iss_datay  <= ZERO;
      iss_target <= '0;
    end else if (rdy) begin
      iss_valid <= do_issue;
      if (do_issue) begin
        iss_op     <= sel_ent.op;
        iss_pc     <= sel_ent.pc;
        iss_datax  <= sel_ent.datax;
        iss_datay  <= sel_ent.datay;
        iss_target <= sel_ent.target;
      end
    end
  end

`ifdef ALU_RS_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      full_q   <= '0;
    end else if (rdy) begin
      if (do_issue) issued_q <= issued_q + 32'd1;
      if (disp_valid && !disp_ready) full_q <= full_q + 32'd1;
    end
  end

  assign perf_issued      = issued_q;
  assign perf_full_cycles = full_q;
`else
  assign perf_issued      = '0;
  assign perf_full_cycles = '0;
`endif

endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched: table of single-op vectors plus hand-written
// multi-cycle sequences (wakeup, full/age order, flush, rdy freeze, reset).
module tb_alu_rs_sched;
  import alu_rs_sched_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        disp_valid;
  logic        disp_ready;
  sinst_t      disp_op;
  addr_t       disp_pc;
  regtag_t     disp_tagx;
  regtag_t     disp_tagy;
  word_t       disp_datax;
  word_t       disp_datay;
  regaddr_t    disp_target;
  logic        cdb_en;
  regtag_t     cdb_tag;
  word_t       cdb_data;
  logic        alu_ready;
  logic        flush;
  logic        iss_valid;
  sinst_t      iss_op;
  addr_t       iss_pc;
  word_t       iss_datax;
  word_t       iss_datay;
  regaddr_t    iss_target;
  logic [31:0] perf_issued;
  logic [31:0] perf_full_cycles;

  alu_rs_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_pc(disp_pc),
    .disp_tagx(disp_tagx), .disp_tagy(disp_tagy),
    .disp_datax(disp_datax), .disp_datay(disp_datay),
    .disp_target(disp_target),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_ready(alu_ready), .flush(flush),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_pc(iss_pc),
    .iss_datax(iss_datax), .iss_datay(iss_datay), .iss_target(iss_target),
    .perf_issued(perf_issued), .perf_full_cycles(perf_full_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_iss   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    sinst_t   op;
    addr_t    pc;
    regtag_t  tx;
    regtag_t  ty;
    word_t    dx;
    word_t    dy;
    regaddr_t tgt;
    logic     cen;
    regtag_t  ctag;
    word_t    cdata;
    logic     exp_iss;
    word_t    ex;
    word_t    ey;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic idle;
    disp_valid = 1'b0;
    cdb_en     = 1'b0;
    cdb_tag    = '0;
    cdb_data   = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input sinst_t op, input addr_t pc, input regtag_t tx,
                            input regtag_t ty, input word_t dx, input word_t dy,
                            input regaddr_t tgt);
    disp_valid  = 1'b1;
    disp_op     = op;
    disp_pc     = pc;
    disp_tagx   = tx;
    disp_tagy   = ty;
    disp_datax  = dx;
    disp_datay  = dy;
    disp_target = tgt;
  endtask

  task automatic disp_simple(input regtag_t tx, input regtag_t ty, input word_t dx);
    drive_disp(6'd1, 32'h200, tx, ty, dx, 32'd2, 5'd1);
  endtask

  task automatic drive_cdb(input regtag_t tag, input word_t data);
    cdb_en   = 1'b1;
    cdb_tag  = tag;
    cdb_data = data;
  endtask

  task automatic expect_issue(input string name, input word_t dx);
    chk({name, ".valid"}, iss_valid, 1'b1);
    chk({name, ".datax"}, iss_datax, dx);
    n_iss++;
  endtask

  task automatic expect_none(input string name);
    chk(name, iss_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{6'd1, 32'h100, 5'd0, 5'd0, 32'd5,      32'd7,      5'd3, 1'b0, 5'd0, 32'd0,    1'b1, 32'd5,    32'd7};
    vecs[1] = '{6'd2, 32'h104, 5'd0, 5'd4, 32'd1,      32'hdead,   5'd4, 1'b1, 5'd4, 32'd9,    1'b1, 32'd1,    32'd9};
    vecs[2] = '{6'd3, 32'h108, 5'd6, 5'd6, 32'haaaa,   32'hbbbb,   5'd5, 1'b1, 5'd6, 32'h55,   1'b1, 32'h55,   32'h55};
    vecs[3] = '{6'd4, 32'h10c, 5'd0, 5'd0, 32'h11,     32'h22,     5'd6, 1'b1, 5'd0, 32'h99,   1'b1, 32'h11,   32'h22};
    vecs[4] = '{6'd5, 32'h110, 5'd7, 5'd0, 32'd1,      32'd2,      5'd2, 1'b1, 5'd8, 32'h33,   1'b0, 32'd0,    32'd0};
    vecs[5] = '{6'd6, 32'h114, 5'd0, 5'd3, 32'h44,     32'd0,      5'd7, 1'b1, 5'd3, 32'h66,   1'b1, 32'h44,   32'h66};

    rst = 1'b1; rdy = 1'b1; alu_ready = 1'b0;
    disp_op = '0; disp_pc = '0; disp_tagx = '0; disp_tagy = '0;
    disp_datax = '0; disp_datay = '0; disp_target = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("reset.iss_valid", iss_valid, 1'b0);
    chk("reset.iss_op", iss_op, 6'd0);
    chk("reset.iss_pc", iss_pc, 32'd0);
    chk("reset.iss_datax", iss_datax, 32'd0);
    chk("reset.iss_datay", iss_datay, 32'd0);
    chk("reset.iss_target", iss_target, 5'd0);
    chk("reset.disp_ready", disp_ready, 1'b1);

    // single-op vectors: dispatch (with optional same-cycle CDB), then issue
    alu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_disp(vecs[i].op, vecs[i].pc, vecs[i].tx, vecs[i].ty, vecs[i].dx, vecs[i].dy, vecs[i].tgt);
      if (vecs[i].cen) drive_cdb(vecs[i].ctag, vecs[i].cdata);
      tick();
      chk($sformatf("vec%0d.latency", i), iss_valid, 1'b0);
      idle();
      tick();
      if (vecs[i].exp_iss) begin
        chk($sformatf("vec%0d.valid", i), iss_valid, 1'b1);
        chk($sformatf("vec%0d.datax", i), iss_datax, vecs[i].ex);
        chk($sformatf("vec%0d.datay", i), iss_datay, vecs[i].ey);
        chk($sformatf("vec%0d.op", i), iss_op, vecs[i].op);
        chk($sformatf("vec%0d.pc", i), iss_pc, vecs[i].pc);
        chk($sformatf("vec%0d.target", i), iss_target, vecs[i].tgt);
        n_iss++;
      end else begin
        chk($sformatf("vec%0d.blocked", i), iss_valid, 1'b0);
        flush = 1'b1;
      end
      tick();
      flush = 1'b0;
      chk($sformatf("vec%0d.pulse_end", i), iss_valid, 1'b0);
    end

    // CDB wakeup of a waiting entry
    disp_simple(5'd3, 5'd0, 32'd0);
    tick(); idle();
    expect_none("wake.before");
    drive_cdb(5'd3, 32'h10);
    tick(); idle();
    expect_none("wake.edge");
    tick();
    expect_issue("wake.issue", 32'h10);
    tick();
    expect_none("wake.end");

    // fill, then issue in dispatch (age) order, not index order
    alu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d.ready", k), disp_ready, 1'b1);
      disp_simple(5'd0, 5'd0, 32'd100 + 32'(k));
      tick(); idle();
    end
    chk("full.disp_ready", disp_ready, 1'b0);
    expect_none("full.no_issue");
    alu_ready = 1'b1;
    tick();
    expect_issue("full.first", 32'd100);
    chk("full.freed", disp_ready, 1'b1);
    alu_ready = 1'b0;
    disp_simple(5'd0, 5'd0, 32'd104);
    tick(); idle();
    chk("refull.disp_ready", disp_ready, 1'b0);
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'd100 + 32'(k));
    alu_ready = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      expect_issue("age.order", exp_q.pop_front());
    end
    tick();
    expect_none("age.drained");
    chk("age.disp_ready", disp_ready, 1'b1);

    // flush overrides issue and dispatch
    alu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp_simple(5'd0, 5'd0, 32'd200 + 32'(k));
      tick(); idle();
    end
    alu_ready = 1'b1;
    tick();
    expect_issue("flush.pre", 32'd200);
    flush = 1'b1;
    disp_simple(5'd0, 5'd0, 32'd300);
    tick(); idle();
    expect_none("flush.edge");
    chk("flush.disp_ready", disp_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_none($sformatf("flush.empty%0d", k));
    end

    // rdy low freezes wakeup, dispatch and issue
    alu_ready = 1'b0;
    disp_simple(5'd5, 5'd0, 32'd0);
    tick(); idle();
    disp_simple(5'd0, 5'd0, 32'h77);
    tick(); idle();
    rdy = 1'b0;
    alu_ready = 1'b1;
    drive_cdb(5'd5, 32'h42);
    disp_simple(5'd0, 5'd0, 32'h88);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_none($sformatf("freeze%0d", k));
    end
    idle();
    rdy = 1'b1;
    tick();
    expect_issue("resume.ready", 32'h77);
    tick();
    expect_none("resume.cdb_dropped");
    drive_cdb(5'd5, 32'h42);
    tick(); idle();
    expect_none("resume.wake_edge");
    tick();
    expect_issue("resume.woken", 32'h42);
    tick();
    expect_none("resume.disp_dropped");

`ifdef ALU_RS_PERF_EN
    chk("perf.issued", perf_issued, 32'(n_iss));
`else
    chk("perf.issued", perf_issued, 32'd0);
`endif
    chk("perf.full", perf_full_cycles, 32'd0);

    // asynchronous reset mid-operation abandons entries
    alu_ready = 1'b0;
    disp_simple(5'd0, 5'd0, 32'h500);
    tick(); idle();
    disp_simple(5'd0, 5'd0, 32'h501);
    tick(); idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst.iss_datax", iss_datax, 32'd0);
    chk("midrst.iss_pc", iss_pc, 32'd0);
    chk("midrst.disp_ready", disp_ready, 1'b1);
    alu_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_none($sformatf("midrst.no_issue%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
